// File: rtl/drp_range_access.sv
// DRP sweep engine: one command walks [START..STOP] on a selected channel,
// streaming read words out over valid/ready or writing a fill value to every word.
module drp_range_access #(
  parameter int unsigned C_DRP_ADDR_WIDTH = 16,
  parameter int unsigned C_DRP_DATA_WIDTH = 16,
  parameter int unsigned C_CH_NUM         = 4,
  parameter int unsigned C_TIMEOUT_CYCLES = 1023,
  localparam int unsigned CH_W = (C_CH_NUM > 1) ? $clog2(C_CH_NUM) : 1
) (
  input  logic                                   DRPCLK_I,
  input  logic                                   DRPRSTN_I,
  input  logic                                   CMD_VALID_I,
  output logic                                   CMD_READY_O,
  input  logic                                   CMD_WR_I,
  input  logic [CH_W-1:0]                        CMD_CH_I,
  input  logic [C_DRP_ADDR_WIDTH-1:0]            CMD_START_I,
  input  logic [C_DRP_ADDR_WIDTH-1:0]            CMD_STOP_I,
  input  logic [C_DRP_DATA_WIDTH-1:0]            CMD_WDATA_I,
  output logic [C_DRP_ADDR_WIDTH-1:0]            M_DRPADDR_O,
  output logic [C_DRP_DATA_WIDTH-1:0]            M_DRPDI_O,
  output logic [C_CH_NUM-1:0]                    M_DRPEN_O,
  output logic [C_CH_NUM-1:0]                    M_DRPWE_O,
  input  logic [C_CH_NUM*C_DRP_DATA_WIDTH-1:0]   M_DRPDO_I,
  input  logic [C_CH_NUM-1:0]                    M_DRPRDY_I,
  output logic                                   RD_VALID_O,
  input  logic                                   RD_READY_I,
  output logic [C_DRP_ADDR_WIDTH-1:0]            RD_ADDR_O,
  output logic [C_DRP_DATA_WIDTH-1:0]            RD_DATA_O,
  output logic                                   DONE_O,
  output logic                                   ERR_O,
  output logic                                   TIMEOUT_O
);

  localparam int unsigned AW    = C_DRP_ADDR_WIDTH;
  localparam int unsigned DW    = C_DRP_DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_NEXT, S_FIN
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_wr, w_wr_nxt;
  logic [CH_W-1:0]     r_ch, w_ch_nxt;
  logic [AW-1:0]       r_stop, w_stop_nxt;
  logic [AW-1:0]       r_addr, w_addr_nxt;
  logic [DW-1:0]       r_wdata, w_wdata_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [AW-1:0]       r_rd_addr, w_rd_addr_nxt;
  logic [DW-1:0]       r_rd_data, w_rd_data_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;
  logic                r_to, w_to_nxt;
  logic [C_CH_NUM-1:0] r_en, w_en_nxt;
  logic [C_CH_NUM-1:0] r_we, w_we_nxt;
  logic [DW-1:0]       w_sel_do;
  logic                w_sel_rdy;
  logic                w_ch_ok;

  // Route the selected channel's DO/RDY; other channels are never looked at.
  always_comb begin
    w_sel_do  = '0;
    w_sel_rdy = 1'b0;
    for (int k = 0; k < int'(C_CH_NUM); k++) begin
      if (CH_W'(k) == r_ch) begin
        w_sel_do  = M_DRPDO_I[k*DW +: DW];
        w_sel_rdy = M_DRPRDY_I[k];
      end
    end
  end

  assign w_ch_ok   = (32'(CMD_CH_I) < C_CH_NUM);
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next state, datapath and next registered outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_nxt      = r_wr;
    w_ch_nxt      = r_ch;
    w_stop_nxt    = r_stop;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_cnt_nxt     = r_cnt;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_data_nxt = r_rd_data;
    w_err_nxt     = 1'b0;
    w_to_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CMD_VALID_I) begin
          w_wr_nxt    = CMD_WR_I;
          w_ch_nxt    = CMD_CH_I;
          w_stop_nxt  = CMD_STOP_I;
          w_wdata_nxt = CMD_WDATA_I;
          w_addr_nxt  = CMD_START_I;
          if (!w_ch_ok || (CMD_START_I > CMD_STOP_I)) begin
            w_state_nxt = S_FIN;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_sel_rdy) begin
          if (!r_wr) begin
            w_rd_addr_nxt = r_addr;
            w_rd_data_nxt = w_sel_do;
            w_state_nxt   = S_OUT;
          end else begin
            w_state_nxt = S_NEXT;
          end
        end else if (w_cnt_inc == CNT_W'(C_TIMEOUT_CYCLES)) begin
          w_state_nxt = S_FIN;
          w_err_nxt   = 1'b1;
          w_to_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_OUT: begin
        if (RD_READY_I) w_state_nxt = S_NEXT;
      end
      // Compare before increment so STOP = all-ones terminates without wrapping.
      S_NEXT: begin
        if (r_addr == r_stop) begin
          w_state_nxt = S_FIN;
        end else begin
          w_addr_nxt  = r_addr + AW'(1);
          w_state_nxt = S_ISSUE;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_valid_nxt = (w_state_nxt == S_OUT);
    w_done_nxt  = (w_state_nxt == S_FIN);
    w_en_nxt    = (w_state_nxt == S_ISSUE) ? (C_CH_NUM'(1) << w_ch_nxt) : '0;
    w_we_nxt    = w_en_nxt & {C_CH_NUM{w_wr_nxt}};
  end

  always_ff @(posedge DRPCLK_I or negedge DRPRSTN_I) begin
    if (!DRPRSTN_I) begin
      r_state   <= S_IDLE;
      r_wr      <= 1'b0;
      r_ch      <= '0;
      r_stop    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_to      <= 1'b0;
      r_en      <= '0;
      r_we      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr      <= w_wr_nxt;
      r_ch      <= w_ch_nxt;
      r_stop    <= w_stop_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_ready   <= w_ready_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_to      <= w_to_nxt;
      r_en      <= w_en_nxt;
      r_we      <= w_we_nxt;
    end
  end

  assign CMD_READY_O = r_ready;
  assign M_DRPADDR_O = r_addr;
  assign M_DRPDI_O   = r_wdata;
  assign M_DRPEN_O   = r_en;
  assign M_DRPWE_O   = r_we;
  assign RD_VALID_O  = r_valid;
  assign RD_ADDR_O   = r_rd_addr;
  assign RD_DATA_O   = r_rd_data;
  assign DONE_O      = r_done;
  assign ERR_O       = r_err;
  assign TIMEOUT_O   = r_to;

endmodule
